// File: rtl/fl_fifo_pkt_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fl_fifo_pkt_pkg
//  Purpose  : Shared types and sizing helpers for the FrameLink packet FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
package fl_fifo_pkt_pkg;

    localparam int c_DEF_DATA_WIDTH = 64;
    localparam int c_DEF_REM_WIDTH  = 3;

    typedef struct packed {
        logic sof_n;
        logic eof_n;
        logic sop_n;
        logic eop_n;
    } fl_ctrl_t;

    // Stored word layout at the default data width.
    typedef struct packed {
        logic [c_DEF_DATA_WIDTH-1:0] data;
        logic [c_DEF_REM_WIDTH-1:0]  rem;
        fl_ctrl_t                    ctrl;
    } fl_word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        DROP  = 2'd2
    } wr_state_t;

    // Pointers carry one extra wrap bit above the address.
    function automatic int ptr_width(input int items);
        return $clog2(items) + 1;
    endfunction

    function automatic int rem_width(input int data_width);
        return (data_width / 8 > 1) ? $clog2(data_width / 8) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fl_fifo_pkt_mem.sv
`default_nettype none
// ============================================================================
//  Module   : fl_fifo_pkt_mem
//  Purpose  : Simple dual-port RAM, synchronous write, asynchronous read.
//  Revision : 1.0 - initial release
// ============================================================================
module fl_fifo_pkt_mem #(
    parameter int WIDTH      = 8,
    parameter int ITEMS      = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] r_mem [ITEMS];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/fl_fifo_pkt.sv
`default_nettype none
// ============================================================================
//  Module   : fl_fifo_pkt
//  Purpose  : FrameLink FIFO with cut-through or store-and-forward release,
//             frame discard, oversize-frame dropping and a frame counter.
//  Revision : 1.0 - initial release
// ============================================================================
module fl_fifo_pkt
    import fl_fifo_pkt_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEF_DATA_WIDTH,
    parameter int ITEMS      = 64,
    parameter int STORE_FWD  = 1,
    parameter int REM_WIDTH  = rem_width(DATA_WIDTH),
    parameter int CNT_WIDTH  = ptr_width(ITEMS)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic [REM_WIDTH-1:0]  rx_rem,
    input  logic                  rx_sof_n,
    input  logic                  rx_eof_n,
    input  logic                  rx_sop_n,
    input  logic                  rx_eop_n,
    input  logic                  rx_src_rdy_n,
    output logic                  rx_dst_rdy_n,
    input  logic                  rx_discard,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic [REM_WIDTH-1:0]  tx_rem,
    output logic                  tx_sof_n,
    output logic                  tx_eof_n,
    output logic                  tx_sop_n,
    output logic                  tx_eop_n,
    output logic                  tx_src_rdy_n,
    input  logic                  tx_dst_rdy_n,
    output logic                  full,
    output logic                  empty,
    output logic [CNT_WIDTH-1:0]  status,
    output logic [CNT_WIDTH-1:0]  frame_cnt,
    output logic                  frame_dropped
);

    localparam int                   c_ADDR_WIDTH = CNT_WIDTH - 1;
    localparam logic [CNT_WIDTH-1:0] c_ITEMS      = CNT_WIDTH'(ITEMS);
    localparam logic [CNT_WIDTH-1:0] c_ONE        = CNT_WIDTH'(1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [REM_WIDTH-1:0]  rem;
        fl_ctrl_t              ctrl;
    } word_t;

    word_t                r_out_word;
    word_t                w_rx_word;
    word_t                w_mem_rdata;
    wr_state_t            r_state;
    wr_state_t            w_state_nxt;
    logic [CNT_WIDTH-1:0] r_wr_ptr;
    logic [CNT_WIDTH-1:0] r_commit_ptr;
    logic [CNT_WIDTH-1:0] r_rd_ptr;
    logic [CNT_WIDTH-1:0] r_frame_cnt;
    logic [CNT_WIDTH-1:0] w_wr_ptr_nxt;
    logic [CNT_WIDTH-1:0] w_commit_ptr_nxt;
    logic [CNT_WIDTH-1:0] w_rd_ptr_nxt;
    logic [CNT_WIDTH-1:0] w_frame_cnt_nxt;
    logic [CNT_WIDTH-1:0] w_status;
    logic [CNT_WIDTH-1:0] w_status_nxt;
    logic                 r_out_vld;
    logic                 r_rx_rdy_n;
    logic                 r_dropped;
    logic                 w_full;
    logic                 w_mem_empty;
    logic                 w_rx_xfer;
    logic                 w_tx_xfer;
    logic                 w_tx_eof;
    logic                 w_load;
    logic                 w_eof_in;
    logic                 w_mem_we;
    logic                 w_commit;
    logic                 w_drop;
    logic                 w_rx_rdy_n_nxt;

    assign w_rx_word   = {rx_data, rx_rem, rx_sof_n, rx_eof_n, rx_sop_n, rx_eop_n};
    assign w_status    = r_wr_ptr - r_rd_ptr;
    assign w_full      = (w_status == c_ITEMS);
    assign w_mem_empty = (r_rd_ptr == r_commit_ptr);
    assign w_rx_xfer   = ~rx_src_rdy_n & ~r_rx_rdy_n;
    assign w_tx_xfer   = r_out_vld & ~tx_dst_rdy_n;
    assign w_tx_eof    = w_tx_xfer & ~r_out_word.ctrl.eof_n;
    assign w_load      = ~w_mem_empty & (~r_out_vld | w_tx_xfer);
    assign w_eof_in    = w_rx_xfer & ~rx_eof_n;

    fl_fifo_pkt_mem #(
        .WIDTH      ($bits(word_t)),
        .ITEMS      (ITEMS),
        .ADDR_WIDTH (c_ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (w_mem_we),
        .waddr (r_wr_ptr[c_ADDR_WIDTH-1:0]),
        .wdata (w_rx_word),
        .raddr (r_rd_ptr[c_ADDR_WIDTH-1:0]),
        .rdata (w_mem_rdata)
    );

    // Write-side FSM: frame commit, discard and oversize rollback.
    always_comb begin
        w_state_nxt      = r_state;
        w_wr_ptr_nxt     = r_wr_ptr;
        w_commit_ptr_nxt = r_commit_ptr;
        w_mem_we         = 1'b0;
        w_commit         = 1'b0;
        w_drop           = 1'b0;
        if (STORE_FWD == 0) begin
            w_mem_we         = w_rx_xfer;
            w_wr_ptr_nxt     = w_rx_xfer ? r_wr_ptr + c_ONE : r_wr_ptr;
            w_commit_ptr_nxt = w_wr_ptr_nxt;
            w_commit         = w_eof_in;
            w_state_nxt      = IDLE;
        end else begin
            unique case (r_state)
                IDLE, FRAME: begin
                    // Memory full of one unfinished frame: it can never complete.
                    if (r_state == FRAME && w_full && w_mem_empty) begin
                        w_drop       = 1'b1;
                        w_wr_ptr_nxt = r_commit_ptr;
                        w_state_nxt  = DROP;
                    end else if (w_rx_xfer) begin
                        w_mem_we     = 1'b1;
                        w_wr_ptr_nxt = r_wr_ptr + c_ONE;
                        if (!rx_eof_n) begin
                            w_state_nxt = IDLE;
                            if (rx_discard) begin
                                w_drop       = 1'b1;
                                w_wr_ptr_nxt = r_commit_ptr;
                            end else begin
                                w_commit         = 1'b1;
                                w_commit_ptr_nxt = r_wr_ptr + c_ONE;
                            end
                        end else if (r_state == IDLE && !rx_sof_n) begin
                            w_state_nxt = FRAME;
                        end
                    end
                end
                DROP: begin
                    if (w_eof_in) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_frame_cnt_nxt = r_frame_cnt;
        if (w_commit && !w_tx_eof) begin
            w_frame_cnt_nxt = r_frame_cnt + c_ONE;
        end else if (!w_commit && w_tx_eof) begin
            w_frame_cnt_nxt = r_frame_cnt - c_ONE;
        end
    end

    // Ready is registered, so it is computed from the post-edge occupancy.
    assign w_rd_ptr_nxt   = w_load ? r_rd_ptr + c_ONE : r_rd_ptr;
    assign w_status_nxt   = w_wr_ptr_nxt - w_rd_ptr_nxt;
    assign w_rx_rdy_n_nxt = (w_status_nxt == c_ITEMS) && (w_state_nxt != DROP);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_rd_ptr     <= '0;
            r_frame_cnt  <= '0;
            r_out_vld    <= 1'b0;
            r_rx_rdy_n   <= 1'b1;
            r_dropped    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_commit_ptr <= w_commit_ptr_nxt;
            r_rd_ptr     <= w_rd_ptr_nxt;
            r_frame_cnt  <= w_frame_cnt_nxt;
            r_out_vld    <= w_load | (r_out_vld & ~w_tx_xfer);
            r_rx_rdy_n   <= w_rx_rdy_n_nxt;
            r_dropped    <= w_drop;
        end
    end

    always_ff @(posedge clk) begin
        if (w_load) begin
            r_out_word <= w_mem_rdata;
        end
    end

    // Delimiters are forced inactive whenever the output register is empty.
    assign tx_data       = r_out_word.data;
    assign tx_rem        = r_out_word.rem;
    assign tx_sof_n      = r_out_word.ctrl.sof_n | ~r_out_vld;
    assign tx_eof_n      = r_out_word.ctrl.eof_n | ~r_out_vld;
    assign tx_sop_n      = r_out_word.ctrl.sop_n | ~r_out_vld;
    assign tx_eop_n      = r_out_word.ctrl.eop_n | ~r_out_vld;
    assign tx_src_rdy_n  = ~r_out_vld;
    assign rx_dst_rdy_n  = r_rx_rdy_n;
    assign full          = w_full;
    assign empty         = w_mem_empty;
    assign status        = w_status;
    assign frame_cnt     = r_frame_cnt;
    assign frame_dropped = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_fl_fifo_pkt.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fl_fifo_pkt
//  Purpose  : Scoreboard bench; instance 0 is cut-through, 1 store-and-forward.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fl_fifo_pkt;

    localparam int DW = 32;
    localparam int RW = 2;
    localparam int IT = 16;
    localparam int CW = 5;
    localparam int WW = DW + RW + 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]         reset_n;
    logic [1:0][DW-1:0] rx_data;
    logic [1:0][RW-1:0] rx_rem;
    logic [1:0]         rx_sof_n, rx_eof_n, rx_sop_n, rx_eop_n;
    logic [1:0]         rx_src_rdy_n, rx_discard, tx_dst_rdy_n;
    wire  [1:0]         rx_dst_rdy_n, tx_sof_n, tx_eof_n, tx_sop_n, tx_eop_n;
    wire  [1:0]         tx_src_rdy_n, full, empty, frame_dropped;
    wire  [1:0][DW-1:0] tx_data;
    wire  [1:0][RW-1:0] tx_rem;
    wire  [1:0][CW-1:0] status, frame_cnt;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        fl_fifo_pkt #(
            .DATA_WIDTH (DW),
            .ITEMS      (IT),
            .STORE_FWD  (g),
            .REM_WIDTH  (RW),
            .CNT_WIDTH  (CW)
        ) u_dut (
            .clk           (clk),
            .reset_n       (reset_n[g]),
            .rx_data       (rx_data[g]),
            .rx_rem        (rx_rem[g]),
            .rx_sof_n      (rx_sof_n[g]),
            .rx_eof_n      (rx_eof_n[g]),
            .rx_sop_n      (rx_sop_n[g]),
            .rx_eop_n      (rx_eop_n[g]),
            .rx_src_rdy_n  (rx_src_rdy_n[g]),
            .rx_dst_rdy_n  (rx_dst_rdy_n[g]),
            .rx_discard    (rx_discard[g]),
            .tx_data       (tx_data[g]),
            .tx_rem        (tx_rem[g]),
            .tx_sof_n      (tx_sof_n[g]),
            .tx_eof_n      (tx_eof_n[g]),
            .tx_sop_n      (tx_sop_n[g]),
            .tx_eop_n      (tx_eop_n[g]),
            .tx_src_rdy_n  (tx_src_rdy_n[g]),
            .tx_dst_rdy_n  (tx_dst_rdy_n[g]),
            .full          (full[g]),
            .empty         (empty[g]),
            .status        (status[g]),
            .frame_cnt     (frame_cnt[g]),
            .frame_dropped (frame_dropped[g])
        );
    end

    int n_tests = 0;
    int n_fail  = 0;
    int drops [2];
    int peak;
    logic [WW-1:0] q0 [$];
    logic [WW-1:0] q1 [$];
    logic [WW-1:0] mon_act, mon_exp;
    logic          mon_have;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every TX transfer is compared with the head of that instance's queue.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (frame_dropped[d] === 1'b1) drops[d]++;
            if (tx_src_rdy_n[d] === 1'b0 && tx_dst_rdy_n[d] === 1'b0) begin
                mon_act  = {tx_data[d], tx_rem[d], tx_sof_n[d], tx_eof_n[d], tx_sop_n[d], tx_eop_n[d]};
                mon_have = (d == 0) ? (q0.size() != 0) : (q1.size() != 0);
                n_tests++;
                if (!mon_have) begin
                    n_fail++;
                    $display("FAIL sb%0d_unexpected: got 0x%0h, expected no word", d, mon_act);
                end else begin
                    mon_exp = (d == 0) ? q0.pop_front() : q1.pop_front();
                    if (mon_act !== mon_exp) begin
                        n_fail++;
                        $display("FAIL sb%0d_word: got 0x%0h, expected 0x%0h", d, mon_act, mon_exp);
                    end
                end
            end
        end
        if (frame_cnt[1] !== 'x && int'(frame_cnt[1]) > peak) peak = int'(frame_cnt[1]);
    end

    task automatic send(input int d, input logic [DW-1:0] data, input logic [RW-1:0] rem,
                        input logic sof_n, input logic eof_n, input logic disc, input bit push);
        int budget;
        budget = 0;
        rx_data[d]      = data;
        rx_rem[d]       = rem;
        rx_sof_n[d]     = sof_n;
        rx_eof_n[d]     = eof_n;
        rx_sop_n[d]     = sof_n;
        rx_eop_n[d]     = eof_n;
        rx_discard[d]   = disc;
        rx_src_rdy_n[d] = 1'b0;
        if (push) begin
            if (d == 0) q0.push_back({data, rem, sof_n, eof_n, sof_n, eof_n});
            else        q1.push_back({data, rem, sof_n, eof_n, sof_n, eof_n});
        end
        while (rx_dst_rdy_n[d] !== 1'b0 && budget < 200) begin
            @(posedge clk); #1;
            budget++;
        end
        if (budget >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL send%0d_timeout: got rx_dst_rdy_n=%b, expected 0", d, rx_dst_rdy_n[d]);
        end else begin
            @(posedge clk); #1;
        end
        rx_src_rdy_n[d] = 1'b1;
        rx_discard[d]   = 1'b0;
    endtask

    task automatic send_frame(input int d, input int n, input logic [DW-1:0] base,
                              input logic disc, input bit push);
        for (int i = 0; i < n; i++) begin
            send(d, base + DW'(i), RW'(i), (i != 0), (i != n - 1), disc && (i == n - 1), push);
        end
    endtask

    task automatic wait_drain(input int d);
        int b;
        b = 0;
        while (((d == 0) ? q0.size() : q1.size()) != 0 && b < 300) begin
            @(negedge clk);
            b++;
        end
        chk($sformatf("drain%0d", d), (d == 0) ? q0.size() : q1.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int dref;
        int b;
        reset_n      = 2'b00;
        rx_data      = '0;
        rx_rem       = '0;
        rx_sof_n     = 2'b11;
        rx_eof_n     = 2'b11;
        rx_sop_n     = 2'b11;
        rx_eop_n     = 2'b11;
        rx_src_rdy_n = 2'b11;
        rx_discard   = 2'b00;
        tx_dst_rdy_n = 2'b11;
        drops[0]     = 0;
        drops[1]     = 0;
        peak         = 0;
        repeat (3) @(posedge clk);
        #1 reset_n = 2'b11;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst%0d_flags", d),
                {tx_src_rdy_n[d], empty[d], full[d], tx_sof_n[d], rx_dst_rdy_n[d]}, 5'b11011);
            chk($sformatf("rst%0d_status", d), status[d], 0);
        end
        @(posedge clk); #1;

        // Cut-through latency and back-to-back delivery.
        tx_dst_rdy_n[0] = 1'b0;
        send(0, 32'hA000, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("ct_not_yet", tx_src_rdy_n[0], 1);
        send(0, 32'hA001, 2'd1, 1'b1, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("ct_sof_valid", {tx_src_rdy_n[0], tx_sof_n[0]}, 2'b00);
        send(0, 32'hA002, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk("ct_fcnt1", frame_cnt[0], 1);
        chk("ct_consec1", tx_src_rdy_n[0], 0);
        @(negedge clk);
        chk("ct_consec2", {tx_src_rdy_n[0], tx_eof_n[0]}, 2'b00);
        @(negedge clk);
        chk("ct_fcnt0", {frame_cnt[0], tx_src_rdy_n[0]}, {5'd0, 1'b1});
        wait_drain(0);

        // Store-and-forward holds the frame until EOF is stored.
        tx_dst_rdy_n[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(1, 32'hB000 + DW'(i), RW'(i), (i != 0), 1'b1, 1'b0, 1'b1);
        end
        @(negedge clk);
        chk("sf_hold_pre", tx_src_rdy_n[1], 1);
        send(1, 32'hB004, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("sf_status5", status[1], 5);
        chk("sf_hold_eof", tx_src_rdy_n[1], 1);
        chk("sf_fcnt1", frame_cnt[1], 1);
        @(negedge clk);
        chk("sf_first", {tx_src_rdy_n[1], tx_sof_n[1]}, 2'b00);
        wait_drain(1);
        @(negedge clk);
        chk("sf_fcnt0", frame_cnt[1], 0);

        // Discarded middle frame.
        tx_dst_rdy_n[1] = 1'b1;
        peak = 0;
        dref = drops[1];
        send_frame(1, 4, 32'hC000, 1'b0, 1'b1);
        send_frame(1, 3, 32'hC100, 1'b1, 1'b0);
        send_frame(1, 2, 32'hC200, 1'b0, 1'b1);
        @(negedge clk);
        chk("disc_drops", drops[1] - dref, 1);
        chk("disc_status", status[1], 5);
        tx_dst_rdy_n[1] = 1'b0;
        wait_drain(1);
        @(negedge clk);
        chk("disc_peak", peak, 2);
        chk("disc_fcnt0", frame_cnt[1], 0);

        // Oversize frame is rolled back and its tail absorbed.
        tx_dst_rdy_n[1] = 1'b1;
        dref = drops[1];
        for (int i = 0; i < 16; i++) begin
            send(1, 32'hD000 + DW'(i), RW'(i), (i != 0), 1'b1, 1'b0, 1'b0);
        end
        @(negedge clk);
        chk("ovs_full", {full[1], rx_dst_rdy_n[1], frame_dropped[1]}, 3'b110);
        @(negedge clk);
        chk("ovs_pulse", frame_dropped[1], 1);
        chk("ovs_status0", status[1], 0);
        for (int i = 16; i < 20; i++) begin
            send(1, 32'hD000 + DW'(i), RW'(i), 1'b1, (i != 19), 1'b0, 1'b0);
        end
        @(negedge clk);
        chk("ovs_drops", drops[1] - dref, 1);
        chk("ovs_fcnt", {status[1], frame_cnt[1]}, 10'd0);
        send_frame(1, 3, 32'hE000, 1'b0, 1'b1);
        @(negedge clk);
        chk("ovs_next_status", status[1], 3);
        tx_dst_rdy_n[1] = 1'b0;
        wait_drain(1);

        // Full with committed data ahead: backpressure, no drop.
        tx_dst_rdy_n[1] = 1'b1;
        dref = drops[1];
        send_frame(1, 10, 32'hF000, 1'b0, 1'b1);
        fork
            send_frame(1, 10, 32'hF100, 1'b0, 1'b1);
            begin
                b = 0;
                while (status[1] !== 5'd16 && b < 100) begin
                    @(negedge clk);
                    b++;
                end
                chk("bp_status16", status[1], 16);
                repeat (3) @(negedge clk);
                chk("bp_rdy", rx_dst_rdy_n[1], 1);
                chk("bp_nodrop", drops[1] - dref, 0);
                tx_dst_rdy_n[1] = 1'b0;
            end
        join
        wait_drain(1);
        @(negedge clk);
        chk("bp_fcnt0", frame_cnt[1], 0);

        // Reset mid-frame, then a clean frame.
        tx_dst_rdy_n[1] = 1'b1;
        send(1, 32'h9000, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        send(1, 32'h9001, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        reset_n[1] = 1'b0;
        @(posedge clk); #1;
        reset_n[1] = 1'b1;
        @(negedge clk);
        chk("mrst_flags", {tx_src_rdy_n[1], empty[1], full[1], frame_dropped[1],
                           tx_sof_n[1], tx_eof_n[1], tx_sop_n[1], tx_eop_n[1], rx_dst_rdy_n[1]},
            9'b1100_1111_1);
        chk("mrst_counts", {status[1], frame_cnt[1]}, 10'd0);
        tx_dst_rdy_n[1] = 1'b0;
        send_frame(1, 3, 32'h7000, 1'b0, 1'b1);
        wait_drain(1);
        @(negedge clk);
        chk("mrst_fcnt0", frame_cnt[1], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fl_fifo_pkt.md
Name: fl_fifo_pkt

Overview:
FrameLink FIFO, next generation of the team's FL FIFO. Parametrised data width and depth. Adds a store-and-forward mode that releases a frame to TX only after its EOF has been stored, sender-requested frame discard, automatic dropping of frames too large to fit, and a complete-frame counter. Sits between FrameLink producers and consumers wherever whole-frame buffering or frame filtering is needed.

Parameters:
DATA_WIDTH, 64, FL data width in bits; multiple of 8, at least 8.
ITEMS, 64, storage depth in words; power of 2, at least 4.
STORE_FWD, 1, 1 = store-and-forward mode; 0 = cut-through mode.
REM_WIDTH, log2(DATA_WIDTH/8) (minimum 1), DREM width.
CNT_WIDTH, log2(ITEMS)+1, width of the STATUS and FRAME_CNT outputs.

Ports:
CLK  in  1  clock.
RESET_N  in  1  reset; synchronous, active-low.
RX_DATA/RX_REM  in  DATA_WIDTH/REM_WIDTH  write data and valid-byte remainder.
RX_SOF_N/RX_EOF_N/RX_SOP_N/RX_EOP_N  in  1 each  frame and part delimiters.
RX_SRC_RDY_N  in  1  write word valid.
RX_DST_RDY_N  out  1  FIFO can accept a word.
RX_DISCARD  in  1  sampled on the EOF beat only; 1 = drop the whole frame.
TX_DATA/TX_REM/TX_SOF_N/TX_EOF_N/TX_SOP_N/TX_EOP_N  out  as RX  read word.
TX_SRC_RDY_N  out  1  read word valid.
TX_DST_RDY_N  in  1  consumer ready.
FULL  out  1  memory occupancy equals ITEMS.
EMPTY  out  1  no committed word available to the read side.
STATUS  out  CNT_WIDTH  words in memory (wr_ptr - rd_ptr); the output register is not counted.
FRAME_CNT  out  CNT_WIDTH  committed complete frames not yet fully read.
FRAME_DROPPED  out  1  one-cycle pulse on the edge a frame is rolled back.

Behaviour:
- Transfer rule: a word moves on a rising edge when both SRC_RDY_N and DST_RDY_N are 0 on that port.
- Pointers: wr_ptr, commit_ptr and rd_ptr are each CNT_WIDTH bits and use the wrap bit.
  - FULL when (wr_ptr - rd_ptr) == ITEMS.
  - Read side is empty when rd_ptr == commit_ptr.
- Stored word: {data, rem, sof_n, eof_n, sop_n, eop_n}. Memory has synchronous write and asynchronous read.
- Output register: loads from memory when it is empty, or when it is consumed in the same cycle. This gives full throughput of one word per cycle.
- Latency, cut-through (STORE_FWD=0):
  - commit_ptr always equals wr_ptr.
  - A word accepted on edge k is valid on TX after edge k+1.
  - RX_DISCARD is ignored and frames are never dropped.
- Latency, store-and-forward (STORE_FWD=1):
  - commit_ptr moves to wr_ptr+1 on acceptance of an EOF word with RX_DISCARD=0.
  - The frame's first word is valid on TX after the EOF edge + 1.
- Write FSM (STORE_FWD=1 only):
  - IDLE -> FRAME: on SOF accepted without EOF.
  - FRAME -> IDLE: on EOF accepted.
  - Discard: EOF accepted with RX_DISCARD=1 sets wr_ptr to commit_ptr. FRAME_DROPPED pulses and FRAME_CNT is unchanged.
  - Oversize frame: in FRAME with FULL=1 and rd_ptr == commit_ptr, the frame cannot complete.
    - Set wr_ptr to commit_ptr, pulse FRAME_DROPPED, go to DROP.
  - DROP: RX_DST_RDY_N=0; words are accepted and discarded; DROP -> IDLE on EOF accepted.
  - Single-word frame (SOF and EOF on one beat): commits or discards immediately and stays in IDLE.
- RX_DST_RDY_N:
  - 1 when FULL and not in DROP.
  - 1 during reset and on the first cycle after RESET_N rises.
  - 0 otherwise.
- FULL with committed data ahead: normal backpressure only, no drop.
- FRAME_CNT:
  - +1 on a committing EOF; -1 on a TX EOF transfer.
  - Both in the same cycle: unchanged.
  - In cut-through mode it counts EOFs written minus EOFs read.
- Reset (RESET_N=0 sampled on an edge, including mid-frame):
  - All pointers and FRAME_CNT cleared; FSM goes to IDLE; output register emptied.
  - TX_SRC_RDY_N=1, EMPTY=1, FULL=0, STATUS=0, FRAME_DROPPED=0.
  - TX_DATA is don't-care; SOF/EOF/SOP/EOP outputs = 1.
  - Any partial frame is lost.
- Simultaneous read and write at FULL: only a word read from memory frees space. An accept requires RX_DST_RDY_N=0, which is registered from the previous state.
- No protocol checking: a SOF arriving in FRAME is stored as data.

Decomposition:
- Package fl_fifo_pkt_pkg:
  - fl_word_t struct, parametrised via the parameter defaults.
  - wr_state_t enum {IDLE, FRAME, DROP}.
  - Pointer-width constant function.
- Sub-module fl_fifo_pkt_mem: simple dual-port RAM, ITEMS deep, synchronous write, asynchronous read.

Test Plan:
- STORE_FWD=0: 3-word frame with TX ready -> TX_SOF_N falls 2 edges after the first RX accept; 3 consecutive TX words; FRAME_CNT goes 1 then 0.
- STORE_FWD=1: 5-word frame -> TX_SRC_RDY_N stays 1 until the edge after EOF accept; STATUS=5 before the read starts.
- STORE_FWD=1: frame A (4 words), frame B (3 words, RX_DISCARD=1 on EOF), frame C (2 words) -> TX outputs A then C; one FRAME_DROPPED pulse; FRAME_CNT peaks at 2.
- ITEMS=16, TX stalled, 20-word frame -> drop on the 16th accept; remaining 4 words are absorbed; then a 3-word frame passes intact; STATUS=3.
- ITEMS=16, one 10-word committed frame and TX stalled, then a 10-word frame -> RX_DST_RDY_N=1 at STATUS=16 with no drop; both frames delivered after TX is released.
- RESET_N=0 for 1 cycle mid-frame -> all outputs at reset values; the next frame is transferred correctly.
